// File: rtl/regmodel0_mutex_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regmodel0_mutex_pkg
// Brief    : Shared types and default widths for the regmodel0 mutex bank.
// Revision : 1.0 - initial release
// ============================================================================
package regmodel0_mutex_pkg;

    localparam int c_num_mutex_dflt = 8;
    localparam int c_swid_w_dflt    = 31;
    localparam int c_reqinfo_w_dflt = 6;
    localparam int c_lease_w_dflt   = 16;

    typedef enum logic [1:0] {
        NONE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2,
        REJECT  = 2'd3
    } access_result_e;

    typedef struct packed {
        logic                        lock;
        logic [c_swid_w_dflt-1:0]    owner_swid;
        logic [c_reqinfo_w_dflt-1:0] owner_reqinfo;
    } mutex_entry_t;

endpackage
`default_nettype wire

// File: rtl/regmodel0_mutex_entry.sv
`default_nettype none
// ============================================================================
// Module   : regmodel0_mutex_entry
// Brief    : One mutex entry: owner state, ownership compare, optional lease
//            counter (MUTEX_LEASE_TIMEOUT_EN).
// Revision : 1.0 - initial release
// ============================================================================
module regmodel0_mutex_entry
    import regmodel0_mutex_pkg::*;
#(
    parameter int SWID_W    = c_swid_w_dflt,
`ifdef MUTEX_LEASE_TIMEOUT_EN
    parameter int LEASE_W   = c_lease_w_dflt,
`endif
    parameter int REQINFO_W = c_reqinfo_w_dflt
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req,
    input  logic                 acquire,
    input  logic [SWID_W-1:0]    swid_din,
    input  logic [REQINFO_W-1:0] reqinfo,
`ifdef MUTEX_LEASE_TIMEOUT_EN
    input  logic [LEASE_W-1:0]   lease_limit,
    output logic                 expire,
`endif
    output logic                 lock,
    output logic [SWID_W-1:0]    owner_swid,
    output access_result_e       result
);

    logic                 r_lock;
    logic [SWID_W-1:0]    r_swid;
    logic [REQINFO_W-1:0] r_reqinfo;
    logic                 w_match;
    logic                 w_expire;

    assign w_match = r_lock && (r_swid == swid_din) && (r_reqinfo == reqinfo);

    always_comb begin
        result = NONE;
        if (req) begin
            if (acquire) begin
                result = (!r_lock || w_match) ? GRANT : REJECT;
            end else begin
                result = w_match ? RELEASE : REJECT;
            end
        end
    end

`ifdef MUTEX_LEASE_TIMEOUT_EN
    logic [LEASE_W-1:0] r_cnt;

    // An owner renew or release in the expiry cycle takes priority over expiry.
    assign w_expire = r_lock && (r_cnt == LEASE_W'(1)) && (lease_limit != '0)
                      && (result != RELEASE) && (result != GRANT);
    assign expire   = w_expire;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (result == GRANT) begin
            r_cnt <= lease_limit;
        end else if (result == RELEASE || w_expire) begin
            r_cnt <= '0;
        end else if (r_lock && r_cnt != '0) begin
            r_cnt <= r_cnt - LEASE_W'(1);
        end
    end
`else
    assign w_expire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lock    <= 1'b0;
            r_swid    <= '0;
            r_reqinfo <= '0;
        end else if (result == GRANT) begin
            r_lock    <= 1'b1;
            r_swid    <= swid_din;
            r_reqinfo <= reqinfo;
        end else if (result == RELEASE || w_expire) begin
            r_lock    <= 1'b0;
            r_swid    <= '0;
            r_reqinfo <= '0;
        end
    end

    assign lock       = r_lock;
    assign owner_swid = r_swid;

endmodule
`default_nettype wire

// File: rtl/regmodel0_mutex_bank.sv
`default_nettype none
// ============================================================================
// Module   : regmodel0_mutex_bank
// Brief    : Indexed bank of NUM_MUTEX hardware mutexes with ownership-checked
//            release; optional lease timeout under MUTEX_LEASE_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module regmodel0_mutex_bank
    import regmodel0_mutex_pkg::*;
#(
    parameter int NUM_MUTEX = c_num_mutex_dflt,
    parameter int SWID_W    = c_swid_w_dflt,
    parameter int REQINFO_W = c_reqinfo_w_dflt,
`ifdef MUTEX_LEASE_TIMEOUT_EN
    parameter int LEASE_W   = c_lease_w_dflt,
`endif
    parameter int IDX_W     = (NUM_MUTEX > 1) ? $clog2(NUM_MUTEX) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IDX_W-1:0]     sel,
    input  logic [REQINFO_W-1:0] reqinfo,
    input  logic [SWID_W-1:0]    swid_din,
    input  logic                 swid_w,
    input  logic                 swid_r,
    input  logic                 lock_din,
    input  logic                 lock_w,
`ifdef MUTEX_LEASE_TIMEOUT_EN
    input  logic [LEASE_W-1:0]   lease_limit,
    output logic                 timeout_pulse,
`endif
    output logic [SWID_W-1:0]    swid_qout,
    output logic                 lock_qout,
    output logic                 acq_ok,
    output logic                 err,
    output logic [NUM_MUTEX-1:0] lock_vec
);

    logic                 w_wr_any;
    logic                 w_wr_ok;
    logic                 w_sel_hit;
    logic [NUM_MUTEX-1:0] w_hit;
    logic [NUM_MUTEX-1:0] w_lock;
    logic [NUM_MUTEX-1:0] w_grant;
    logic [NUM_MUTEX-1:0] w_reject;
    logic [NUM_MUTEX-1:0] w_expire;
    logic [SWID_W-1:0]    w_swid [NUM_MUTEX];
    logic [SWID_W-1:0]    w_rd_swid;
    logic                 w_rd_lock;
    logic                 w_err_next;

    logic [SWID_W-1:0]    r_swid_qout;
    logic                 r_lock_qout;
    logic                 r_acq_ok;
    logic                 r_err;

    assign w_wr_any  = lock_w | swid_w;
    assign w_wr_ok   = lock_w & swid_w;
    // Out-of-range indices simply match no entry.
    assign w_sel_hit = |w_hit;

    generate
        for (genvar i = 0; i < NUM_MUTEX; i++) begin : g_entry
            access_result_e w_res;

            assign w_hit[i] = (sel == IDX_W'(i));

            regmodel0_mutex_entry #(
                .SWID_W    (SWID_W),
`ifdef MUTEX_LEASE_TIMEOUT_EN
                .LEASE_W   (LEASE_W),
`endif
                .REQINFO_W (REQINFO_W)
            ) u_entry (
                .clk         (clk),
                .rst         (rst),
                .req         (w_wr_ok & w_hit[i]),
                .acquire     (lock_din),
                .swid_din    (swid_din),
                .reqinfo     (reqinfo),
`ifdef MUTEX_LEASE_TIMEOUT_EN
                .lease_limit (lease_limit),
                .expire      (w_expire[i]),
`endif
                .lock        (w_lock[i]),
                .owner_swid  (w_swid[i]),
                .result      (w_res)
            );

`ifndef MUTEX_LEASE_TIMEOUT_EN
            assign w_expire[i] = 1'b0;
`endif
            assign w_grant[i]  = (w_res == GRANT);
            assign w_reject[i] = (w_res == REJECT);
        end
    endgenerate

    always_comb begin
        w_rd_swid = '0;
        w_rd_lock = 1'b0;
        for (int k = 0; k < NUM_MUTEX; k++) begin
            if (w_hit[k]) begin
                w_rd_swid = w_swid[k];
                w_rd_lock = w_lock[k];
            end
        end
    end

    assign w_err_next = w_wr_any & (~w_wr_ok | ~w_sel_hit | (|w_reject));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_swid_qout <= '0;
            r_lock_qout <= 1'b0;
            r_acq_ok    <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            if (swid_r) begin
                r_swid_qout <= w_rd_swid;
                r_lock_qout <= w_rd_lock;
            end
            r_acq_ok <= |w_grant;
            r_err    <= w_err_next;
        end
    end

`ifdef MUTEX_LEASE_TIMEOUT_EN
    logic r_timeout;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= |w_expire;
        end
    end

    assign timeout_pulse = r_timeout;
`else
    logic w_unused_expire;
    assign w_unused_expire = |w_expire;
`endif

    assign swid_qout = r_swid_qout;
    assign lock_qout = r_lock_qout;
    assign acq_ok    = r_acq_ok;
    assign err       = r_err;
    assign lock_vec  = w_lock;

endmodule
`default_nettype wire

// File: tb/tb_regmodel0_mutex_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_regmodel0_mutex_bank
// Brief    : Directed, table-driven bench for regmodel0_mutex_bank
//            (lease checks compiled in with MUTEX_LEASE_TIMEOUT_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_regmodel0_mutex_bank;

    localparam int c_n  = 8;
    localparam int c_sw = 31;
    localparam int c_ri = 6;
    localparam int c_ix = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [c_ix-1:0] sel;
    logic [c_ri-1:0] reqinfo;
    logic [c_sw-1:0] swid_din;
    logic            swid_w, swid_r, lock_din, lock_w;
    logic [c_sw-1:0] swid_qout;
    logic            lock_qout, acq_ok, err;
    logic [c_n-1:0]  lock_vec;
`ifdef MUTEX_LEASE_TIMEOUT_EN
    logic [15:0]     lease_limit;
    logic            timeout_pulse;
`endif

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    regmodel0_mutex_bank #(
        .NUM_MUTEX (c_n),
        .SWID_W    (c_sw),
        .REQINFO_W (c_ri),
`ifdef MUTEX_LEASE_TIMEOUT_EN
        .LEASE_W   (16),
`endif
        .IDX_W     (c_ix)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .sel           (sel),
        .reqinfo       (reqinfo),
        .swid_din      (swid_din),
        .swid_w        (swid_w),
        .swid_r        (swid_r),
        .lock_din      (lock_din),
        .lock_w        (lock_w),
`ifdef MUTEX_LEASE_TIMEOUT_EN
        .lease_limit   (lease_limit),
        .timeout_pulse (timeout_pulse),
`endif
        .swid_qout     (swid_qout),
        .lock_qout     (lock_qout),
        .acq_ok        (acq_ok),
        .err           (err),
        .lock_vec      (lock_vec)
    );

    typedef struct {
        logic [c_ix-1:0] sel;
        logic [c_ri-1:0] ri;
        logic [c_sw-1:0] swid;
        logic            sw, sr, ld, lw;
        logic [c_sw-1:0] e_swid;
        logic            e_lock, e_acq, e_err;
        logic [c_n-1:0]  e_vec;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [c_ix-1:0] s, input logic [c_ri-1:0] r,
                                input logic [c_sw-1:0] id, input logic sw, input logic sr,
                                input logic ld, input logic lw, input logic [c_sw-1:0] es,
                                input logic el, input logic ea, input logic ee,
                                input logic [c_n-1:0] ev);
        vec_t v;
        v.sel = s; v.ri = r; v.swid = id; v.sw = sw; v.sr = sr; v.ld = ld; v.lw = lw;
        v.e_swid = es; v.e_lock = el; v.e_acq = ea; v.e_err = ee; v.e_vec = ev;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic idle();
        swid_w = 0; swid_r = 0; lock_w = 0; lock_din = 0;
        sel = '0; reqinfo = '0; swid_din = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [c_ix-1:0] s, input logic [c_ri-1:0] r,
                         input logic [c_sw-1:0] id, input logic sw, input logic sr,
                         input logic ld, input logic lw);
        sel = s; reqinfo = r; swid_din = id; swid_w = sw; swid_r = sr;
        lock_din = ld; lock_w = lw;
    endtask

    initial begin
        rst = 1'b1;
        idle();
`ifdef MUTEX_LEASE_TIMEOUT_EN
        lease_limit = '0;
`endif
        step(); step();
        chk("rst_swid_qout", 32'(swid_qout), 32'h0);
        chk("rst_lock_qout", 32'(lock_qout), 32'h0);
        chk("rst_acq_ok",    32'(acq_ok),    32'h0);
        chk("rst_err",       32'(err),       32'h0);
        chk("rst_lock_vec",  32'(lock_vec),  32'h0);
        rst = 1'b0;

        //          sel ri  swid         sw sr ld lw   e_swid       el ea ee vec
        tbl.push_back(mk(3, 0, 31'h0,       0, 1, 0, 0,  31'h0,       0, 0, 0, 8'h00));
        tbl.push_back(mk(2, 5, 31'h1234,    1, 0, 1, 1,  31'h0,       0, 1, 0, 8'h04));
        tbl.push_back(mk(2, 0, 31'h0,       0, 1, 0, 0,  31'h1234,    1, 0, 0, 8'h04));
        tbl.push_back(mk(2, 5, 31'h55,      1, 0, 1, 1,  31'h1234,    1, 0, 1, 8'h04));
        tbl.push_back(mk(2, 0, 31'h0,       0, 1, 0, 0,  31'h1234,    1, 0, 0, 8'h04));
        tbl.push_back(mk(2, 5, 31'h55,      1, 0, 0, 1,  31'h1234,    1, 0, 1, 8'h04));
        tbl.push_back(mk(2, 6, 31'h1234,    1, 0, 0, 1,  31'h1234,    1, 0, 1, 8'h04));
        tbl.push_back(mk(2, 5, 31'h1234,    1, 1, 0, 1,  31'h1234,    1, 0, 0, 8'h00));
        tbl.push_back(mk(2, 0, 31'h0,       0, 1, 0, 0,  31'h0,       0, 0, 0, 8'h00));
        tbl.push_back(mk(2, 5, 31'h1234,    1, 0, 0, 1,  31'h0,       0, 0, 1, 8'h00));
        tbl.push_back(mk(9, 1, 31'h77,      1, 0, 1, 1,  31'h0,       0, 0, 1, 8'h00));
        tbl.push_back(mk(7, 63, 31'h7FFFFFFF, 1, 0, 1, 1, 31'h0,      0, 1, 0, 8'h80));
        tbl.push_back(mk(7, 0, 31'h0,       0, 1, 0, 0,  31'h7FFFFFFF, 1, 0, 0, 8'h80));
        tbl.push_back(mk(9, 0, 31'h0,       0, 1, 0, 0,  31'h0,       0, 0, 0, 8'h80));
        tbl.push_back(mk(7, 63, 31'h7FFFFFFF, 0, 0, 0, 1, 31'h0,      0, 0, 1, 8'h80));
        tbl.push_back(mk(7, 63, 31'h7FFFFFFF, 1, 0, 0, 0, 31'h0,      0, 0, 1, 8'h80));
        tbl.push_back(mk(7, 63, 31'h7FFFFFFF, 1, 0, 1, 1, 31'h0,      0, 1, 0, 8'h80));
        tbl.push_back(mk(0, 0, 31'h1,       1, 0, 1, 1,  31'h0,       0, 1, 0, 8'h81));
        tbl.push_back(mk(0, 0, 31'h0,       0, 0, 0, 0,  31'h0,       0, 0, 0, 8'h81));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].sel, tbl[i].ri, tbl[i].swid, tbl[i].sw, tbl[i].sr, tbl[i].ld, tbl[i].lw);
            step();
            chk($sformatf("v%0d_swid_qout", i), 32'(swid_qout), 32'(tbl[i].e_swid));
            chk($sformatf("v%0d_lock_qout", i), 32'(lock_qout), 32'(tbl[i].e_lock));
            chk($sformatf("v%0d_acq_ok", i),    32'(acq_ok),    32'(tbl[i].e_acq));
            chk($sformatf("v%0d_err", i),       32'(err),       32'(tbl[i].e_err));
            chk($sformatf("v%0d_lock_vec", i),  32'(lock_vec),  32'(tbl[i].e_vec));
        end
        idle();

        // Reset while entries are held drops every lock and clears qout.
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst2_lock_vec",  32'(lock_vec),  32'h0);
        chk("rst2_swid_qout", 32'(swid_qout), 32'h0);
        drive(7, 0, 31'h0, 0, 1, 0, 0);
        step();
        idle();
        chk("rst2_read_lock", 32'(lock_qout), 32'h0);

`ifdef MUTEX_LEASE_TIMEOUT_EN
        lease_limit = 16'd10;
        drive(0, 1, 31'hA, 1, 0, 1, 1);
        step();
        idle();
        chk("lease_acq_ok", 32'(acq_ok), 32'h1);
        for (int k = 1; k <= 9; k++) step();
        chk("lease_held_c9", 32'(lock_vec[0]), 32'h1);
        chk("lease_nopulse_c9", 32'(timeout_pulse), 32'h0);
        step();
        chk("lease_drop_c10", 32'(lock_vec[0]), 32'h0);
        chk("lease_pulse_c10", 32'(timeout_pulse), 32'h1);
        step();
        chk("lease_pulse_c11", 32'(timeout_pulse), 32'h0);

        drive(0, 1, 31'hA, 1, 0, 1, 1);
        step();
        idle();
        for (int k = 1; k <= 4; k++) step();
        drive(0, 1, 31'hA, 1, 0, 1, 1);
        step();
        idle();
        chk("renew_acq_ok", 32'(acq_ok), 32'h1);
        for (int k = 6; k <= 14; k++) step();
        chk("renew_held_c14", 32'(lock_vec[0]), 32'h1);
        chk("renew_nopulse_c14", 32'(timeout_pulse), 32'h0);
        step();
        chk("renew_drop_c15", 32'(lock_vec[0]), 32'h0);
        chk("renew_pulse_c15", 32'(timeout_pulse), 32'h1);

        drive(1, 2, 31'hB, 1, 0, 1, 1);
        step();
        idle();
        for (int k = 1; k <= 3; k++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (timeout_pulse !== 1'b0) chk("rst_lease_pulse", 32'(timeout_pulse), 32'h0);
        end
        chk("rst_lease_vec", 32'(lock_vec), 32'h0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
